// File: rtl/dequantization_fc.sv
`default_nettype none
// ============================================================================
// Module      : dequantization_fc
// Description : Streaming int8 -> int32 dequantizer for one FC layer row.
//               Computes sat32(((code - Q_ZERO) * Q_MULT) >>> Q_SHIFT) in a
//               three-stage valid/ready pipeline. It tracks element position
//               within a LEN-long vector and pulses done after the last one.
// Revision    : 1.0 - initial release
// ============================================================================
module dequantization_fc #(
   parameter logic signed [7:0]  Q_ZERO  = -8'sd4,
   parameter logic signed [31:0] Q_MULT  = 32'sh00000100,
   parameter int unsigned        Q_SHIFT = 4,
   parameter int unsigned        LEN     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [7:0]  in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [31:0] out_data,
   output logic               out_last,
   output logic               done
);

   localparam logic [15:0] LAST_IDX = 16'(LEN - 1);

   // Pipeline state: one valid bit plus payload per stage
   logic               v1_q, v2_q, v3_q;
   logic signed [8:0]  d1_q;
   logic signed [40:0] p2_q;
   logic signed [31:0] data3_q;
   logic [15:0]        count_q;
   logic               done_q;

   // Next-state values
   logic signed [8:0]  d1_d;
   logic signed [40:0] p2_d;
   logic signed [40:0] shifted;
   logic signed [31:0] data3_d;
   logic [15:0]        count_d;
   logic               advance;
   logic               transfer;
   logic               last_hit;

   // Handshake: the whole pipe moves only when the output slot can drain
   always_comb begin
      advance  = en && (!v3_q || out_ready);
      transfer = en && v3_q && out_ready;
      last_hit = (count_q == LAST_IDX);
      count_d  = last_hit ? 16'd0 : count_q + 16'd1;
   end

   // Arithmetic: zero-point removal, scale, floor shift, int32 saturation
   always_comb begin
      d1_d    = 9'(in_data) - 9'(Q_ZERO);
      p2_d    = 41'(d1_q) * 41'(Q_MULT);
      shifted = p2_q >>> Q_SHIFT;
      // Bits above 31 must all match the int32 sign bit, otherwise clamp
      if (shifted[40:31] != {10{shifted[31]}}) begin
         data3_d = shifted[40] ? 32'sh80000000 : 32'sh7FFFFFFF;
      end else begin
         data3_d = shifted[31:0];
      end
   end

   // Three-stage datapath; disabling the block drops everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         d1_q    <= '0;
         p2_q    <= '0;
         data3_q <= '0;
      end else if (!en) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else if (advance) begin
         v1_q    <= in_valid;
         d1_q    <= d1_d;
         v2_q    <= v1_q;
         p2_q    <= p2_d;
         v3_q    <= v2_q;
         data3_q <= data3_d;
      end
   end

   // Element counter and end-of-vector pulse; en low also restarts the vector
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= transfer && last_hit;
         if (transfer) begin
            count_q <= count_d;
         end
      end
   end

   assign in_ready  = advance;
   assign out_valid = v3_q;
   assign out_data  = data3_q;
   assign out_last  = v3_q && last_hit;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dequantization_fc.sv
`default_nettype none
// ============================================================================
// Module      : tb_dequantization_fc
// Description : Scoreboard bench for dequantization_fc. Instance 0 uses the
//               default scale with LEN=4; instance 1 uses Q_MULT=0x7FFFFFFF,
//               Q_SHIFT=0, LEN=1 to reach the saturation limits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dequantization_fc;

   localparam logic signed [7:0]  QZ   = -8'sd4;
   localparam logic signed [31:0] QM_A = 32'sh00000100;
   localparam logic signed [31:0] QM_B = 32'sh7FFFFFFF;

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       en, in_valid, in_ready, out_valid, out_ready, out_last, done;
   logic [1:0][7:0]  in_data;
   logic [1:0][31:0] out_data;
   logic [1:0]       chk_lat;
   int               cyc     = 0;
   int               n_tests = 0;
   int               n_fail  = 0;

   always #5 clk = ~clk;

   // Edge counter used to measure acceptance-to-transfer latency
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: floor((code - Q_ZERO) * mult / 2^shift), clamped to int32
   function automatic logic [31:0] model(input int k, input logic signed [7:0] code);
      longint p, d, q;
      p = (longint'(code) - longint'(QZ)) * ((k == 0) ? longint'(QM_A) : longint'(QM_B));
      d = 64'sd1 << ((k == 0) ? 4 : 0);
      if (p >= 0) q = p / d;
      else        q = -((-p + d - 1) / d);
      if (q > 64'sd2147483647)  return 32'h7FFFFFFF;
      if (q < -64'sd2147483648) return 32'h80000000;
      return q[31:0];
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam int unsigned L = (k == 0) ? 4 : 1;

      dequantization_fc #(
         .Q_ZERO  (QZ),
         .Q_MULT  ((k == 0) ? QM_A : QM_B),
         .Q_SHIFT ((k == 0) ? 4 : 0),
         .LEN     (L)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .en        (en[k]),
         .in_valid  (in_valid[k]),
         .in_ready  (in_ready[k]),
         .in_data   (in_data[k]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k]),
         .out_data  (out_data[k]),
         .out_last  (out_last[k]),
         .done      (done[k])
      );

      exp_t sb[$];
      int   icnt     = 0;
      int   pending  = 0;
      logic exp_done = 1'b0;

      // Scoreboard: push on input acceptance, compare/pop on output transfer
      always @(negedge clk) begin
         exp_t e;
         logic nd;
         if (rst || !en[k]) begin
            sb.delete();
            icnt     = 0;
            exp_done = 1'b0;
         end else begin
            if (done[k] || exp_done) chk($sformatf("done[%0d]", k), done[k], exp_done);
            nd = 1'b0;
            if (out_valid[k]) begin
               if (sb.size() == 0) begin
                  chk($sformatf("spurious[%0d]", k), out_valid[k], 1'b0);
               end else begin
                  chk($sformatf("data[%0d]", k), out_data[k], sb[0].data);
                  chk($sformatf("last[%0d]", k), out_last[k], sb[0].last);
                  if (out_ready[k]) begin
                     e  = sb.pop_front();
                     nd = e.last;
                     if (chk_lat[k]) chk($sformatf("latency[%0d]", k), 32'(cyc + 1 - e.cyc), 32'd3);
                  end
               end
            end
            exp_done = nd;
            if (in_valid[k] && in_ready[k]) begin
               e.data = model(k, in_data[k]);
               e.last = (icnt == int'(L) - 1);
               e.cyc  = cyc + 1;
               sb.push_back(e);
               icnt = (icnt == int'(L) - 1) ? 0 : icnt + 1;
            end
         end
         pending = sb.size();
      end
   end

   function automatic int pend(input int k);
      return (k == 0) ? g_dut[0].pending : g_dut[1].pending;
   endfunction

   // Call right after posedge+1; returns right after the accepting edge +1
   task automatic send(input int k, input logic signed [7:0] code);
      int n = 0;
      in_valid[k] = 1'b1;
      in_data[k]  = code;
      @(negedge clk);
      while (!in_ready[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1 in_valid[k] = 1'b0;
   endtask

   task automatic drain(input int k);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (pend(k) != 0 && n < 200);
      if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; en = 2'b11; in_valid = '0; in_data = '0;
      out_ready = 2'b11; chk_lat = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_valid", out_valid[k], 1'b0);
         chk("rst_data",  out_data[k],  32'd0);
         chk("rst_last",  out_last[k],  1'b0);
         chk("rst_done",  done[k],      1'b0);
      end
      @(posedge clk);
      #1 rst = 1'b0;

      // Basic values on the default scale; the fourth element closes the vector
      send(0, 8'sd10);
      drain(0);
      send(0, -8'sd128);
      send(0, -8'sd5);
      send(0, 8'sd127);
      drain(0);

      // Full vector 0..3 with a 5-cycle downstream stall in the middle
      chk_lat[0] = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(0, 8'(i));
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready[0] = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready[0] = 1'b1;
         end
      join
      drain(0);

      // Two elements in flight, then en dropped for one cycle
      out_ready[0] = 1'b0;
      send(0, 8'sd5);
      send(0, 8'sd6);
      @(posedge clk);
      #1 en[0] = 1'b0;
      @(posedge clk);
      #1 en[0] = 1'b1;
      out_ready[0] = 1'b1;
      @(negedge clk);
      chk("en_flush_valid", out_valid[0], 1'b0);
      chk("en_flush_done",  done[0],      1'b0);
      repeat (4) @(posedge clk);
      #1;

      // Two elements in flight, then a one-cycle reset
      out_ready[0] = 1'b0;
      send(0, 8'sd7);
      send(0, 8'sd8);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready[0] = 1'b1;
      @(negedge clk);
      chk("rst_flush_valid", out_valid[0], 1'b0);
      chk("rst_flush_last",  out_last[0],  1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Fresh vector must start at element 0 and finish with last + done
      chk_lat[0] = 1'b1;
      for (int i = 1; i <= 4; i++) send(0, 8'(i));
      drain(0);

      // Saturation limits and exact boundaries, LEN=1 (every element is last)
      send(1, 8'sd127);
      send(1, -8'sd128);
      send(1, -8'sd3);
      send(1, -8'sd5);
      drain(1);

      // en drops in the cycle of an output transfer: no done pulse
      send(1, 8'sd20);
      n = 0;
      while (!out_valid[1] && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("en_win_wait", out_valid[1], 1'b1);
      en[1] = 1'b0;
      @(posedge clk);
      #1 en[1] = 1'b1;
      @(negedge clk);
      chk("en_win_done",  done[1],      1'b0);
      chk("en_win_valid", out_valid[1], 1'b0);
      @(posedge clk);
      #1;
      send(1, -8'sd4);
      drain(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
